// File: rtl/vga_pkg.sv
// 640x480 VGA timing constants, derived sync windows and the shared coordinate/colour types.
package vga_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [23:0] rgb_t;

    localparam coord_t H_ACTIVE = 11'd640;
    localparam coord_t H_FP     = 11'd16;
    localparam coord_t H_SYNC   = 11'd96;
    localparam coord_t H_BP     = 11'd48;
    localparam coord_t V_ACTIVE = 11'd480;
    localparam coord_t V_FP     = 11'd10;
    localparam coord_t V_SYNC   = 11'd2;
    localparam coord_t V_BP     = 11'd33;

    localparam coord_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam coord_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are half-open: START is the first low count, END the first high one.
    localparam coord_t HS_START = H_ACTIVE + H_FP;
    localparam coord_t HS_END   = HS_START + H_SYNC;
    localparam coord_t VS_START = V_ACTIVE + V_FP;
    localparam coord_t VS_END   = VS_START + V_SYNC;

    // Eight 80-pixel colour bars: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_color(coord_t x);
        rgb_t color;
        if      (x < 11'd80)  color = 24'hFFFFFF;
        else if (x < 11'd160) color = 24'hFFFF00;
        else if (x < 11'd240) color = 24'h00FFFF;
        else if (x < 11'd320) color = 24'h00FF00;
        else if (x < 11'd400) color = 24'hFF00FF;
        else if (x < 11'd480) color = 24'hFF0000;
        else if (x < 11'd560) color = 24'h0000FF;
        else                  color = 24'h000000;
        return color;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-rate divider followed by the horizontal and vertical raster counters.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic   clk,
    input  logic   rst,
    output logic   pix_tick,
    output coord_t div,
    output coord_t hcount,
    output coord_t vcount,
    output logic   wrap
);

    localparam coord_t DIV_LAST = coord_t'(CLK_DIV - 1);
    localparam coord_t H_LAST   = H_TOTAL - 11'd1;
    localparam coord_t V_LAST   = V_TOTAL - 11'd1;

    logic line_end;
    logic frame_end;

    always_comb begin
        pix_tick  = (div == DIV_LAST);
        line_end  = (hcount == H_LAST);
        frame_end = (vcount == V_LAST);
        wrap      = line_end && frame_end;
    end

    // NOTE: registers take non-blocking assignments so every always_ff reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            hcount <= '0;
            vcount <= '0;
        end else if (pix_tick) begin
            div <= '0;
            if (line_end) begin
                hcount <= '0;
                vcount <= frame_end ? '0 : vcount + 11'd1;
            end else begin
                hcount <= hcount + 11'd1;
            end
        end else begin
            div <= div + 11'd1;
        end
    end

endmodule

// File: rtl/vga_controller.sv
// 640x480 VGA controller: raster counters, registered sync/blank/colour, DAC pixel clock.
// Optional colour-bar generator with a pattern_sel input when VGA_TEST_PATTERN_EN is defined.
module vga_controller
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] in_color,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    output logic [10:0] pixelx,
    output logic [10:0] pixely,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        vga_clk,
    output logic        frame_start
);

    localparam coord_t VGA_CLK_HIGH = coord_t'(CLK_DIV / 2);

    logic   pix_tick;
    logic   wrap;
    coord_t div;
    coord_t div_next;
    coord_t hcount;
    coord_t vcount;
    logic   active;
    logic   hs_zone;
    logic   vs_zone;
    rgb_t   src_color;

    vga_timing_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick),
        .div      (div),
        .hcount   (hcount),
        .vcount   (vcount),
        .wrap     (wrap)
    );

    assign pixelx = hcount;
    assign pixely = vcount;

    // NOTE: every variable here is assigned on every path, so no latch is inferred.
    always_comb begin
        div_next = pix_tick ? '0 : div + 11'd1;
        active   = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
        hs_zone  = (hcount >= HS_START) && (hcount < HS_END);
        vs_zone  = (vcount >= VS_START) && (vcount < VS_END);
`ifdef VGA_TEST_PATTERN_EN
        src_color = pattern_sel ? bar_color(hcount) : in_color;
`else
        src_color = in_color;
`endif
    end

    // The pixel clock follows the divider value the counter is about to hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            vga_clk     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_clk     <= (div_next >= VGA_CLK_HIGH);
            frame_start <= pix_tick && wrap;
            if (pix_tick) begin
                {r, g, b} <= active ? src_color : 24'h000000;
                hsync     <= !hs_zone;
                vsync     <= !vs_zone;
                blank_n   <= active;
            end
        end
    end

endmodule
